alu_shift_unit: RTL
===================

ALU_SHIFT_UNIT -- requirements
Module: alu_shift_unit

Interface
REQ-001 Parameter WIDTH, default 32: datapath width in bits.
REQ-002 Parameter SHW, default 5: shift-amount width; 2**SHW SHALL equal WIDTH.
REQ-003 clk_i  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 start_i  input  1  request strobe; sampled only in IDLE.
REQ-006 operacion_i  input  4  ALU operation code: 4'b0111 SRL, 4'b1000 SLL, 4'b1001 SRA; any other code is invalid.
REQ-007 a_i  input  WIDTH  operand to shift (rs/rt value from register file).
REQ-008 shamt_i  input  SHW  shift amount, unsigned.
REQ-009 busy_o  output  1  high while a request is in progress (states SHIFT and DONE).
REQ-010 done_o  output  1  one-cycle pulse; resultado_o valid in that cycle.
REQ-011 resultado_o  output  WIDTH  shift result; holds value until the next accepted start.
REQ-012 zero_o  output  1  high when resultado_o equals 0.

Function
REQ-013 The block SHALL perform the shift operations the ALU bit-slice array returns as 0, iteratively, one bit position per clock.
REQ-014 FSM states SHALL be IDLE, SHIFT, DONE; encoding free.
REQ-015 IDLE with start_i=1 at an edge: latch a_i into the working register, shamt_i into the counter, operacion_i into the op register; go to SHIFT if shamt_i!=0, else DONE.
REQ-016 IDLE with start_i=0: stay in IDLE; working register and outputs unchanged.
REQ-017 SHIFT, each edge: SLL shifts left, filling 0; SRL shifts right, filling 0; SRA shifts right, filling the current MSB; counter decrements by 1.
REQ-018 SHIFT with counter==1 at an edge: perform the final shift and go to DONE.
REQ-019 Invalid op code: on acceptance, working register SHALL be forced to 0 and the FSM SHALL go directly to DONE regardless of shamt_i.
REQ-020 DONE: done_o=1 for exactly one cycle; next edge SHALL go to IDLE unconditionally.
REQ-021 Latency: done_o SHALL be high in the cycle following edge k+N, where k is the accepting edge and N=shamt_i (N=0 for invalid op).
REQ-022 start_i SHALL be ignored in SHIFT and DONE; no queueing; latched inputs are unaffected by input changes after acceptance.
REQ-023 start_i high in the same cycle as done_o SHALL be ignored; a new request is accepted no earlier than the cycle after done_o.
REQ-024 resultado_o SHALL be driven from the working register; intermediate values while in SHIFT are don't-care to consumers, only the done_o cycle is valid.
REQ-025 zero_o SHALL be combinational from resultado_o.
REQ-026 shamt_i=WIDTH-1 SHALL complete normally (maximum latency WIDTH-1+1 cycles).

Reset
REQ-027 rst_i=1 at an edge SHALL force state IDLE, working register 0, counter 0, op register 0, regardless of current state.
REQ-028 After reset: busy_o=0, done_o=0, resultado_o=0, zero_o=1.
REQ-029 Reset mid-SHIFT SHALL abort the request with no done_o pulse; rst_i has priority over start_i.

Verification
REQ-030 SLL: a_i=32'h0000_0001, shamt_i=4, start at edge k -> done_o high only after edge k+4, resultado_o=32'h0000_0010, zero_o=0, busy_o high 5 cycles.
REQ-031 SRA vs SRL: a_i=32'h8000_0000, shamt_i=31 -> SRA gives 32'hFFFF_FFFF; SRL gives 32'h0000_0001; both done after edge k+31.
REQ-032 Zero shift: a_i=32'hDEAD_BEEF, shamt_i=0, op SLL -> done_o after edge k, resultado_o=32'hDEAD_BEEF.
REQ-033 Invalid op 4'b0010 with a_i=32'hFFFF_FFFF, shamt_i=7 -> done_o after edge k, resultado_o=0, zero_o=1.
REQ-034 Busy blocking: start SLL shamt_i=3, re-assert start_i with different a_i during SHIFT and in done cycle -> single done_o, result from first operands only.
REQ-035 Reset mid-op: start SRL shamt_i=20, rst_i=1 at edge k+5 -> IDLE, resultado_o=0, no done_o; a start one cycle later completes normally.

Source files
------------

// File: rtl/alu_shift_unit.sv
// Iterative shifter for the ALU shift operations (SLL, SRL, SRA).
// The operand moves one bit position per clock. done_o pulses for one
// cycle when resultado_o holds the final value.
//
// state | meaning
// IDLE  | waiting for start_i; result register holds the last value
// SHIFT | shifting one bit per clock, counter counts down to 1
// DONE  | result valid, done_o high for this single cycle
module alu_shift_unit #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [3:0]       operacion_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [SHW-1:0]   shamt_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] resultado_o,
  output logic             zero_o
);

  localparam logic [3:0] OP_SRL = 4'b0111;
  localparam logic [3:0] OP_SLL = 4'b1000;
  localparam logic [3:0] OP_SRA = 4'b1001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic             op_valid;

  // Only the three shift codes are handled; anything else yields zero at once.
  assign op_valid = (operacion_i == OP_SRL) || (operacion_i == OP_SLL) ||
                    (operacion_i == OP_SRA);

  // Next-state, working register and counter update.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          cnt_d = shamt_i;
          op_d  = operacion_i;
          if (!op_valid) begin
            work_d  = '0;
            state_d = DONE;
          end else begin
            work_d  = a_i;
            state_d = (shamt_i == '0) ? DONE : SHIFT;
          end
        end
      end
      SHIFT: begin
        unique case (op_q)
          OP_SLL:  work_d = {work_q[WIDTH-2:0], 1'b0};
          OP_SRL:  work_d = {1'b0, work_q[WIDTH-1:1]};
          OP_SRA:  work_d = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
          default: work_d = work_q;
        endcase
        cnt_d = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous reset taking priority over start_i.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  // Status outputs decoded from the current state and working register.
  always_comb begin
    busy_o      = (state_q == SHIFT) || (state_q == DONE);
    done_o      = (state_q == DONE);
    resultado_o = work_q;
    zero_o      = (work_q == '0);
  end

endmodule
